// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: FSM state codes, handshake levels
// and the decode aluop codes that select div/divu.
package div_iter_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    // aluop codes produced by decode for the divide instructions
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_iter.sv
// Iterative restoring divider (one quotient bit per clock) for div/divu.
// Optional zero-divisor short cut enabled by defining DIV_BY_ZERO_DETECT_EN.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int                 CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DATA_W);
    localparam logic [DATA_W-1:0]  OP_ZERO  = {DATA_W{1'b0}};
    localparam logic [2*DATA_W-1:0] RES_ZERO = {(2*DATA_W){1'b0}};
    localparam logic [2*DATA_W:0]  DVD_ZERO = {(2*DATA_W+1){1'b0}};

`ifdef DIV_BY_ZERO_DETECT_EN
    localparam logic ZERO_DETECT = 1'b1;
`else
    localparam logic ZERO_DETECT = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] twos_neg(input logic [DATA_W-1:0] v);
        return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

    div_state_e          state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [2*DATA_W:0]   dividend_r;
    logic [DATA_W-1:0]   divisor_r;
    logic                neg_quot_r;
    logic                neg_rem_r;

    logic [DATA_W-1:0]   op1_abs_s;
    logic [DATA_W-1:0]   op2_abs_s;
    logic                div_by_zero_s;
    logic [DATA_W:0]     tmp_s;
    logic [2*DATA_W:0]   step_s;
    logic [DATA_W-1:0]   quot_s;
    logic [DATA_W-1:0]   rem_s;

    // operand magnitudes, one trial-subtract step, and the sign-corrected final result
    always_comb begin
        op1_abs_s     = opdata1_i;
        op2_abs_s     = opdata2_i;
        div_by_zero_s = (opdata2_i == OP_ZERO);

        if (signed_div_i && opdata1_i[DATA_W-1]) begin
            op1_abs_s = twos_neg(opdata1_i);
        end else begin
            op1_abs_s = opdata1_i;
        end

        if (signed_div_i && opdata2_i[DATA_W-1]) begin
            op2_abs_s = twos_neg(opdata2_i);
        end else begin
            op2_abs_s = opdata2_i;
        end

        // borrow out of the 33-bit subtract means the divisor does not fit
        tmp_s = {1'b0, dividend_r[2*DATA_W-1:DATA_W]} - {1'b0, divisor_r};
        if (tmp_s[DATA_W]) begin
            step_s = {dividend_r[2*DATA_W-1:0], 1'b0};
        end else begin
            step_s = {tmp_s[DATA_W-1:0], dividend_r[DATA_W-1:0], 1'b1};
        end

        if (neg_quot_r) begin
            quot_s = twos_neg(dividend_r[DATA_W-1:0]);
        end else begin
            quot_s = dividend_r[DATA_W-1:0];
        end

        if (neg_rem_r) begin
            rem_s = twos_neg(dividend_r[2*DATA_W:DATA_W+1]);
        end else begin
            rem_s = dividend_r[2*DATA_W:DATA_W+1];
        end
    end

    // divider FSM: load, 32 shift-subtract steps, result hand-off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= DivFree;
            cnt_r      <= CNT_ZERO;
            dividend_r <= DVD_ZERO;
            divisor_r  <= OP_ZERO;
            neg_quot_r <= 1'b0;
            neg_rem_r  <= 1'b0;
            result_o   <= RES_ZERO;
            ready_o    <= DivResultNotReady;
        end else begin
            case (state_r)
                DivFree: begin
                    result_o <= RES_ZERO;
                    ready_o  <= DivResultNotReady;
                    if (start_i == DivStart && !annul_i) begin
                        if (ZERO_DETECT && div_by_zero_s) begin
                            state_r <= DivByZero;
                        end else begin
                            state_r    <= DivOn;
                            cnt_r      <= CNT_ZERO;
                            divisor_r  <= op2_abs_s;
                            dividend_r <= {OP_ZERO, op1_abs_s, 1'b0};
                            neg_quot_r <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                            neg_rem_r  <= signed_div_i & opdata1_i[DATA_W-1];
                        end
                    end else begin
                        state_r <= DivFree;
                    end
                end
                DivByZero: begin
                    state_r  <= DivEnd;
                    result_o <= RES_ZERO;
                    ready_o  <= DivResultReady;
                end
                DivOn: begin
                    if (annul_i) begin
                        state_r  <= DivFree;
                        cnt_r    <= CNT_ZERO;
                        result_o <= RES_ZERO;
                        ready_o  <= DivResultNotReady;
                    end else if (cnt_r != CNT_LAST) begin
                        dividend_r <= step_s;
                        cnt_r      <= cnt_r + CNT_ONE;
                        result_o   <= RES_ZERO;
                        ready_o    <= DivResultNotReady;
                    end else begin
                        state_r  <= DivEnd;
                        cnt_r    <= CNT_ZERO;
                        result_o <= {rem_s, quot_s};
                        ready_o  <= DivResultReady;
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        state_r  <= DivFree;
                        result_o <= RES_ZERO;
                        ready_o  <= DivResultNotReady;
                    end else begin
                        state_r <= DivEnd;
                    end
                end
                default: begin
                    state_r  <= DivFree;
                    cnt_r    <= CNT_ZERO;
                    result_o <= RES_ZERO;
                    ready_o  <= DivResultNotReady;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Randomized self-checking bench for div_iter against an arithmetic reference model.
// Honours DIV_BY_ZERO_DETECT_EN the same way the design does.
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int          vectors;
    int          miscompares;
    bit          chk_en;
    logic        exp_ready;
    logic [63:0] exp_result;

    div_iter #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected {remainder, quotient} straight from integer division rules
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        logic [31:0] q;
        logic [31:0] r;
        longint      sa;
        longint      sb;
        if (b == 32'd0) begin
`ifdef DIV_BY_ZERO_DETECT_EN
            return 64'd0;
`else
            r = a;
            q = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
            return {r, q};
`endif
        end
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic int latency(input logic [31:0] b);
`ifdef DIV_BY_ZERO_DETECT_EN
        if (b == 32'd0) return 2;
`endif
        return 34;
    endfunction

    task automatic check(input string name, input logic [64:0] got, input logic [64:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // cycle-by-cycle comparison against the model's expected outputs
    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (ready !== exp_ready || result !== exp_result) begin
                miscompares++;
                $display("FAIL cycle t=%0t: ready=%0b result=%h, expected ready=%0b result=%h",
                         $time, ready, result, exp_ready, exp_result);
            end
        end
    end

    // follow edges from..to of a running job; operands are scrambled once latched
    task automatic track(input int from, input int to, input int lat, input logic [63:0] er);
        for (int k = from; k <= to; k++) begin
            @(posedge clk);
            #1;
            exp_ready  = (k >= lat);
            exp_result = (k >= lat) ? er : 64'd0;
            if (k == 1) begin
                opdata1    = $urandom;
                opdata2    = $urandom;
                signed_div = 1'($urandom);
            end
        end
    endtask

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit sgn, input int pre);
        logic [63:0] er;
        int          lat;
        er  = model(a, b, sgn);
        lat = latency(b);
        @(negedge clk);
        opdata1    = a;
        opdata2    = b;
        signed_div = sgn;
        start      = 1'b1;
        annul      = (pre > 0);
        repeat (pre) @(posedge clk);
        if (pre > 0) begin
            #1;
            annul = 1'b0;
        end
        track(1, lat + 2, lat, er);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        exp_ready  = 1'b0;
        exp_result = 64'd0;
        @(negedge clk);
    endtask

    task automatic do_annul(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        @(negedge clk);
        opdata1    = a;
        opdata2    = b;
        signed_div = sgn;
        start      = 1'b1;
        track(1, 11, 34, 64'd0);
        annul = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        annul = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_at(input logic [31:0] a, input logic [31:0] b, input bit sgn, input int n);
        logic [63:0] er;
        int          lat;
        er  = model(a, b, sgn);
        lat = latency(b);
        @(negedge clk);
        opdata1    = a;
        opdata2    = b;
        signed_div = sgn;
        start      = 1'b1;
        track(1, n, lat, er);
        #2;
        rst        = 1'b1;
        start      = 1'b0;
        exp_ready  = 1'b0;
        exp_result = 64'd0;
        #1;
        check("async_reset", {ready, result}, 65'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rs;
        vectors     = 0;
        miscompares = 0;
        chk_en      = 1'b0;
        exp_ready   = 1'b0;
        exp_result  = 64'd0;
        rst         = 1'b1;
        start       = 1'b0;
        annul       = 1'b0;
        signed_div  = 1'b0;
        opdata1     = 32'd0;
        opdata2     = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {ready, result}, 65'd0);
        @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        check("model_100_7",  {1'b0, model(32'd100, 32'd7, 1'b0)},                    {1'b0, 64'h00000002_0000000E});
        check("model_m7_2",   {1'b0, model(32'hFFFF_FFF9, 32'd2, 1'b1)},               {1'b0, 64'hFFFFFFFF_FFFFFFFD});
        check("model_7_m2",   {1'b0, model(32'd7, 32'hFFFF_FFFE, 1'b1)},               {1'b0, 64'h00000001_FFFFFFFD});
        check("model_ovf",    {1'b0, model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1)},       {1'b0, 64'h00000000_80000000});
        check("model_9_3",    {1'b0, model(32'd9, 32'd3, 1'b0)},                       {1'b0, 64'h00000000_00000003});
`ifdef DIV_BY_ZERO_DETECT_EN
        check("model_5_0",    {1'b0, model(32'd5, 32'd0, 1'b0)},                       {1'b0, 64'h00000000_00000000});
`else
        check("model_5_0",    {1'b0, model(32'd5, 32'd0, 1'b0)},                       {1'b0, 64'h00000005_FFFFFFFF});
`endif

        do_div(32'd100, 32'd7, 1'b0, 0);
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        do_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        do_div(32'd5, 32'd0, 1'b0, 0);
        do_div(32'hFFFF_FFF9, 32'd0, 1'b1, 0);
        do_div(32'd20, 32'd6, 1'b0, 3);
        do_annul(32'd1000, 32'd3, 1'b0);
        do_div(32'd9, 32'd3, 1'b0, 0);
        reset_at(32'd1000, 32'd3, 1'b0, 15);
        do_div(32'd100, 32'd7, 1'b0, 0);
        reset_at(32'hDEAD_BEEF, 32'd13, 1'b0, 36);
        do_div(32'd100, 32'd7, 1'b0, 0);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rs = 1'($urandom);
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 16);
                2:       rb = 32'd0 - 32'($urandom_range(1, 16));
                default: rb = $urandom;
            endcase
            do_div(ra, rb, rs, ($urandom_range(0, 3) == 0) ? 2 : 0);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative 32-cycle restoring divider for the execute stage. Serves div/divu.
- Consumes the two source operands produced by decode (rs value, rt value) and the signed/unsigned selection derived from the decoded aluop.
- Returns a 64-bit {remainder, quotient} result for the HI/LO write path.
- Execute holds start_i high and asserts a pipeline stall until ready_o is seen.

Parameters:
- DATA_W, 32, operand width; result width is 2*DATA_W. Only 32 is verified.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- signed_div_i  in  1  1 = signed (div), 0 = unsigned (divu).
- opdata1_i  in  DATA_W  dividend (rs).
- opdata2_i  in  DATA_W  divisor (rt).
- start_i  in  1  level request; held high by execute until result taken.
- annul_i  in  1  cancel in-flight division (exception/flush).
- result_o  out  2*DATA_W  {remainder[63:32], quotient[31:0]}.
- ready_o  out  1  result_o valid.

Behaviour:
- Reset (rst=1, async): state=DivFree, cnt=0, working regs=0, result_o=0, ready_o=0.
- States (2-bit): DivFree, DivByZero, DivOn, DivEnd.
- DivFree:
  - start_i=1 and annul_i=0 and divisor==0, with feature enabled -> DivByZero.
  - start_i=1 and annul_i=0 otherwise -> DivOn.
    - Latch divisor magnitude: two's-complement negate if signed and negative.
    - Latch sign flags.
    - dividend reg (65b) = {32'b0, |opdata1|, 1'b0}; cnt=0.
  - Else stay; ready_o=0, result_o=0.
  - Operands are sampled only on the DivFree exit edge; later changes are ignored.
- DivOn, annul_i=1: -> DivFree next edge; ready_o stays 0; no result produced.
- DivOn, cnt<32: one step per edge.
  - tmp = {1'b0, dividend[63:32]} - {1'b0, divisor}.
  - tmp[32]=1: dividend <= dividend<<1.
  - tmp[32]=0: dividend <= {tmp[31:0], dividend[31:0], 1'b1}.
  - cnt++.
- DivOn, cnt==32: -> DivEnd.
  - quotient = dividend[31:0], negated if signed and operand signs differ.
  - remainder = dividend[64:33], negated if signed and dividend negative.
  - result_o <= {remainder, quotient}; ready_o <= 1.
- DivByZero: -> DivEnd next edge with result_o=0, ready_o=1.
- DivEnd:
  - start_i=0 -> DivFree; ready_o<=0, result_o<=0.
  - start_i=1: hold result and ready_o.
- Latency from the first edge seeing start_i=1 (idle unit):
  - Normal case: ready_o high after edge 34 (1 load + 32 steps + 1 finish).
  - Divide-by-zero with feature: ready_o high after edge 2.
- Boundaries:
  - Signed 0x80000000 / 0xFFFFFFFF: magnitude 0x80000000 is treated as unsigned; q=0x80000000, r=0; no trap.
  - start_i and annul_i both high in DivFree: stay DivFree.
  - Async reset mid-DivOn: immediate return to reset values.

Optional Feature:
- Macro: DIV_BY_ZERO_DETECT_EN.
- Defined: a zero divisor takes the DivByZero path; result 0, 2-edge latency.
- Undefined:
  - DivByZero is unreachable; zero divisor runs the full 32 steps.
  - Every step subtracts 0, giving q=0xFFFFFFFF and r=|dividend| before sign correction.
  - Latency is 34 edges.

Decomposition:
- The shared defines file holds:
  - State codes: DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11.
  - DivResultReady/DivResultNotReady.
  - DivStart/DivStop.
  - The new EXE_DIV_OP/EXE_DIVU_OP aluop codes for decode.
- No sub-module; the subtract-shift step and magnitude/negate logic stay inline.

Test Plan:
- Unsigned: signed_div_i=0, 100 / 7 -> after edge 34, ready_o=1, result_o=0x00000002_0000000E. Dropping start_i -> ready_o=0 next edge.
- Signed: 0xFFFFFFF9 (-7) / 2 -> result_o=0xFFFFFFFF_FFFFFFFD (r=-1, q=-3). Also 7 / -2 -> 0x00000001_FFFFFFFD.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF -> result_o=0x00000000_80000000, 34 edges.
- Divide by zero, unsigned 5/0:
  - With DIV_BY_ZERO_DETECT_EN: ready after edge 2, result_o=0.
  - Without: ready after edge 34, result_o=0x00000005_FFFFFFFF.
- Annul: start 1000/3, assert annul_i when cnt=10 -> DivFree next edge, ready_o never rises. A following 9/3 returns 0x00000000_00000003 in 34 edges.
- Async reset: assert rst between edges during DivOn -> ready_o=0, result_o=0 immediately. After release, a new 100/7 completes correctly.
